// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding and frame constants shared by transmitter and receiver (PARITY used with UART_TX_PARITY_EN)
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        WAIT_REL = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit cycle counter; tick marks the last cycle of each serial bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Held at zero while idle so the first bit after a capture is full length.
    always_ff @(posedge clk) begin
        if (clr || restart || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with 4-phase XMT_REQ/XMT_ACK handshake; UART_TX_PARITY_EN adds a parity bit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       XMT_REQ,
    input  logic [7:0] XMT_DATA,
    output logic       XMT_ACK,
    output logic       XMT_BUSY,
    output logic       XMT
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_t state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  idx, idx_n;
    logic        armed, armed_n;
    logic        ack_n, busy_n, xmt_n;
    logic        capture;
    logic        tick;
    logic        bit_en;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_n;
`endif

    assign bit_en = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .clr     (clr),
        .en      (bit_en),
        .restart (capture),
        .tick    (tick)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        armed_n = armed;
        ack_n   = XMT_ACK;
        busy_n  = XMT_BUSY;
        xmt_n   = XMT;
        capture = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_bit;
`endif

        // Handshake release runs independently of frame progress.
        if (!XMT_REQ) begin
            ack_n   = 1'b0;
            armed_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (XMT_REQ && armed) begin
                    capture = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                    xmt_n   = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        xmt_n   = par_bit;
`else
                        state_n = STOP;
                        xmt_n   = UART_STOP_BIT;
`endif
                    end else begin
                        idx_n   = idx + 3'd1;
                        shreg_n = shreg >> 1;
                        xmt_n   = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    xmt_n   = UART_STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // Re-armed producer chains the next start bit with no idle gap.
                    if (XMT_REQ && armed) begin
                        capture = 1'b1;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = XMT_REQ ? WAIT_REL : IDLE;
                    end
                end
            end
            WAIT_REL: begin
                if (!XMT_REQ) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                xmt_n   = UART_STOP_BIT;
                busy_n  = 1'b0;
            end
        endcase

        if (capture) begin
            state_n = START;
            shreg_n = XMT_DATA;
            idx_n   = '0;
            xmt_n   = UART_START_BIT;
            ack_n   = 1'b1;
            busy_n  = 1'b1;
            armed_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n   = (^XMT_DATA) ^ 1'(PARITY_ODD);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            armed    <= 1'b1;
            XMT_ACK  <= 1'b0;
            XMT_BUSY <= 1'b0;
            XMT      <= UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            idx      <= idx_n;
            armed    <= armed_n;
            XMT_ACK  <= ack_n;
            XMT_BUSY <= busy_n;
            XMT      <= xmt_n;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter (honours UART_TX_PARITY_EN)
module tb_uart_transmitter;

    localparam int N = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;

    logic       clk = 1'b0;
    logic       clr;
    logic       req;
    logic [7:0] data;
    logic       ack;
    logic       busy;
    logic       xmt;
    logic       cmp_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT (N),
        .PARITY_ODD   (0)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .XMT_REQ  (req),
        .XMT_DATA (data),
        .XMT_ACK  (ack),
        .XMT_BUSY (busy),
        .XMT      (xmt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a list of line levels, each held N cycles, indexed by time since capture.
    logic m_xmt   = 1'b1;
    logic m_ack   = 1'b0;
    logic m_busy  = 1'b0;
    logic m_armed = 1'b1;
    logic m_cap;
    int   m_t     = 0;
    logic m_bits [0:10];

    always @(posedge clk) begin
        if (clr) begin
            m_xmt = 1'b1; m_ack = 1'b0; m_busy = 1'b0; m_armed = 1'b1; m_t = 0;
        end else begin
            m_cap = 1'b0;
            if (m_busy) begin
                m_t++;
                if (m_t == FRAME) m_busy = 1'b0;
            end
            if (!m_busy && req && m_armed) begin
                m_cap = 1'b1;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = data[i];
                m_bits[9] = ^data;
                m_bits[NBITS-1] = 1'b1;
                m_t = 0;
                m_busy = 1'b1;
            end
            if (m_cap) begin
                m_ack = 1'b1; m_armed = 1'b0;
            end else if (!req) begin
                m_ack = 1'b0; m_armed = 1'b1;
            end
            m_xmt = m_busy ? m_bits[m_t / N] : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_xmt",  32'(xmt),  32'(m_xmt));
            check("model_ack",  32'(ack),  32'(m_ack));
            check("model_busy", 32'(busy), 32'(m_busy));
        end
    end

    task automatic run_frame(input logic [7:0] d, input int drop_at,
                             output logic [10:0] seq, output int busy_cnt);
        seq = '0;
        busy_cnt = 0;
        data = d;
        req = 1'b1;
        @(negedge clk);
        for (int c = 0; c < FRAME + 10; c++) begin
            if ((c % N) == (N / 2) && c < FRAME) seq = {seq[9:0], xmt};
            if (busy) busy_cnt++;
            if (c == drop_at) begin
                req = 1'b0;
                data = ~d;
            end
            @(negedge clk);
        end
    endtask

    logic [10:0] seq;
    logic [10:0] exp_a5, exp_55, exp_07;
    int          busy_cnt;
    int          rises;
    logic        prev_ack;

    initial begin
`ifdef UART_TX_PARITY_EN
        exp_a5 = 11'b01010010101;
        exp_55 = 11'b01010101001;
        exp_07 = 11'b01110000011;
`else
        exp_a5 = 11'b0101001011;
        exp_55 = 11'b0101010101;
        exp_07 = 11'b0111000001;
`endif
        clr = 1'b1; req = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        cmp_en = 1'b1;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_xmt", 32'(xmt), 32'd1);
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        run_frame(8'hA5, 2, seq, busy_cnt);
        check("a5_bits", 32'(seq), 32'(exp_a5));
        check("a5_busy_len", busy_cnt, FRAME);

        // Request held far beyond one frame: one capture, then parked in WAIT_REL.
        data = 8'h3C; req = 1'b1; rises = 0; busy_cnt = 0; prev_ack = ack;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ack && !prev_ack) rises++;
            prev_ack = ack;
            if (busy) busy_cnt++;
        end
        check("hold_frames", rises, 1);
        check("hold_busy_len", busy_cnt, FRAME);
        check("waitrel_busy", 32'(busy), 32'd0);
        check("waitrel_xmt", 32'(xmt), 32'd1);
        check("waitrel_ack", 32'(ack), 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("ack_release", 32'(ack), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back 0x00 then 0xFF, re-requested mid-frame.
        data = 8'h00; req = 1'b1; busy_cnt = 0;
        @(negedge clk);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            if (c == 3) req = 1'b0;
            if (c == 5) begin req = 1'b1; data = 8'hFF; end
            if (c == FRAME + 50) req = 1'b0;
            if (c == 15) check("b2b_first_d0", 32'(xmt), 32'd0);
            if (c == FRAME - 5) check("b2b_first_stop", 32'(xmt), 32'd1);
            if (c == FRAME) check("b2b_second_start", 32'(xmt), 32'd0);
            if (c == FRAME + 15) check("b2b_second_d0", 32'(xmt), 32'd1);
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("b2b_busy_len", busy_cnt, 2 * FRAME);

        // Abort a 0x55 frame at cycle 45, then resend.
        data = 8'h55; req = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 45; c++) begin
            if (c == 2) req = 1'b0;
            @(negedge clk);
        end
        check("pre_abort_xmt", 32'(xmt), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_xmt", 32'(xmt), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        run_frame(8'h55, 2, seq, busy_cnt);
        check("resend_bits", 32'(seq), 32'(exp_55));
        check("resend_busy_len", busy_cnt, FRAME);

        run_frame(8'h07, 4, seq, busy_cnt);
        check("x07_bits", 32'(seq), 32'(exp_07));
        check("x07_busy_len", busy_cnt, FRAME);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
